regfile_rr_arbiter: RTL and testbench
=====================================

Name: regfile_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one internal 32 x 8-bit register array among NREQ requesters.
- Each requester issues single-word read or write transactions using a req/gnt/ack handshake.
- Used in simulator regression designs as the sequential front end to a shared storage resource, alongside plain wires, always blocks and gate instances.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DATA_W, 8, word width.
- ADDR_W, 5, address width; array depth is 2**ADDR_W.

Ports:
- clk  input  1  single clock; all state changes on posedge.
- rst_n  input  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to clk.
- req  input  NREQ  per-requester request, level.
- we  input  NREQ  per-requester write enable (1 = write, 0 = read).
- addr  input  NREQ*ADDR_W  packed addresses; requester k uses bits [k*ADDR_W +: ADDR_W].
- wdata  input  NREQ*DATA_W  packed write data; requester k uses bits [k*DATA_W +: DATA_W].
- gnt  output  NREQ  one-hot grant.
- ack  output  NREQ  one-hot, one-cycle completion pulse.
- rdata  output  DATA_W  transaction data; valid only while ack is nonzero.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset values:
  - gnt = 0, ack = 0, rdata = 0, busy = 0.
  - state = IDLE.
  - round-robin pointer last = NREQ-1, so requester 0 wins first.
  - all array entries = 0.
- States: IDLE, GRANT, ACK.
- IDLE:
  - If req != 0, select the first set bit scanning last+1, last+2, ... modulo NREQ.
  - Register gnt to that one-hot value, set last = winner, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - Sample we/addr/wdata of the winner.
  - If the winner's req is still 1:
    - Write: array[addr] <= wdata and rdata <= wdata.
    - Read: rdata <= array[addr].
    - Set ack = gnt and go to ACK.
  - If the winner's req dropped: abort, no array access, gnt cleared, back to IDLE; last still advanced.
- ACK:
  - ack high for exactly this cycle; gnt held; then gnt = 0, ack = 0, go to IDLE.
- Latency:
  - req seen at edge N gives gnt after edge N and ack after edge N+1.
  - Minimum 3 cycles per transaction; back-to-back arbitration resumes in the IDLE cycle.
- Fairness: a requester holding req continuously is served at least once every NREQ transactions.
- Requests from other requesters during GRANT/ACK are ignored until IDLE; no queueing.
- Same address written then read by a different requester returns the new value; there is no bypass hazard because access is serialized.
- Addresses are always in range (depth = 2**ADDR_W); there is no wrap handling beyond natural truncation.
- rst_n low mid-transaction: immediate return to reset values, array cleared, pending ack lost.
- rdata holds its last value outside ack; benches must not check it then.

Optional Feature:
- Macro: REGFILE_ARB_PARITY_EN.
- Defined:
  - Each entry stores an extra even-parity bit computed from wdata on write.
  - A new output perr (1 bit) pulses with ack when a read's stored parity mismatches recomputed parity.
  - A force port-free bench may inject errors via hierarchical force on the array.
  - perr resets to 0.
- Undefined: no parity storage and no perr port; behaviour otherwise identical.

Test Plan:
- Reset then single write, req[0]=1, we[0]=1, addr0=5'd3, wdata0=8'hA5 -> gnt=4'b0001 after edge 1, ack=4'b0001 with rdata=8'hA5 after edge 2, busy low in cycle 3.
- Read after write: req[2]=1, we[2]=0, addr2=5'd3 -> ack=4'b0100, rdata=8'hA5; read of untouched addr 5'd9 -> rdata=8'h00.
- All four req held high, distinct writes -> grant order 0,1,2,3,0, each requester acked once per 4 transactions, 12 cycles per round.
- Abort: req[1] asserted, dropped in GRANT cycle -> no ack, array[addr1] unchanged, next arbitration starts at requester 2.
- rst_n pulsed low during ACK -> gnt/ack/busy go to 0 immediately without waiting for clk; subsequent read of previously written addr returns 8'h00.
- With REGFILE_ARB_PARITY_EN: write 8'h0F to addr 1, force one data bit flipped, read -> perr=1 coincident with ack; clean read -> perr=0.

Source files
------------

// File: rtl/regfile_rr_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_rr_arbiter
//
// Round-robin arbiter and sequencer in front of a shared 2**ADDR_W x DATA_W
// register array. Each requester issues one single-word read or write at a
// time through a req/gnt/ack handshake:
//   IDLE  -> pick next requester after the last winner, register one-hot gnt
//   GRANT -> if the winner still requests, perform the access; else abort
//   ACK   -> one-cycle ack pulse with rdata, then back to IDLE
//
// Ports:
//   clk    : clock, all state changes on the rising edge
//   rst_n  : asynchronous active-low reset (assert async, release sync)
//   req    : per-requester request level                  [NREQ]
//   we     : per-requester write enable (1 = write)       [NREQ]
//   addr   : packed addresses, requester k at [k*ADDR_W +: ADDR_W]
//   wdata  : packed write data, requester k at [k*DATA_W +: DATA_W]
//   gnt    : one-hot grant, held through GRANT and ACK    [NREQ]
//   ack    : one-hot one-cycle completion pulse           [NREQ]
//   rdata  : transaction data, meaningful only while ack != 0
//   busy   : high whenever the sequencer is not IDLE
//   perr   : (REGFILE_ARB_PARITY_EN only) pulses with ack when a read
//            returns a word whose stored even parity does not match
//
// Optional feature macro: REGFILE_ARB_PARITY_EN
//   Defined   -> each entry carries an even-parity bit, perr port exists.
//   Undefined -> plain data storage, no perr port.
//
// The array is cleared by reset, so it is built from resettable flops
// rather than a RAM macro.
// -----------------------------------------------------------------------------
module regfile_rr_arbiter #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          we,
    input  logic [NREQ*ADDR_W-1:0]   addr,
    input  logic [NREQ*DATA_W-1:0]   wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          ack,
    output logic [DATA_W-1:0]        rdata,
`ifdef REGFILE_ARB_PARITY_EN
    output logic                     perr,
`endif
    output logic                     busy
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int IDX_W = $clog2(NREQ);
`ifdef REGFILE_ARB_PARITY_EN
    localparam int ENTRY_W = DATA_W + 1;   // {parity, data}
`else
    localparam int ENTRY_W = DATA_W;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [NREQ-1:0]     gnt_reg, gnt_next;
    logic [NREQ-1:0]     ack_reg, ack_next;
    logic [DATA_W-1:0]   rdata_reg, rdata_next;
    logic [IDX_W-1:0]    last_reg, last_next;
`ifdef REGFILE_ARB_PARITY_EN
    logic                perr_reg, perr_next;
`endif

    // Unpacked per-requester views of the packed buses
    logic [ADDR_W-1:0]   addr_arr  [NREQ];
    logic [DATA_W-1:0]   wdata_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // While in GRANT/ACK, last_reg is the current winner's index, so it
    // doubles as the select for the winner's request fields.
    logic                sel_req;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    assign sel_req   = req[last_reg];
    assign sel_we    = we[last_reg];
    assign sel_addr  = addr_arr[last_reg];
    assign sel_wdata = wdata_arr[last_reg];

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    logic [ENTRY_W-1:0]  mem_reg [DEPTH];
    logic [ENTRY_W-1:0]  wr_entry;
    logic [ENTRY_W-1:0]  rd_entry;
    logic [DATA_W-1:0]   rd_data;
    logic                mem_wr_en;

`ifdef REGFILE_ARB_PARITY_EN
    // Even parity: stored bit equals XOR of the data, so XOR of the whole
    // entry is zero for an intact word.
    assign wr_entry = {^sel_wdata, sel_wdata};
`else
    assign wr_entry = sel_wdata;
`endif

    assign rd_entry = mem_reg[sel_addr];
    assign rd_data  = rd_entry[DATA_W-1:0];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_reg[gi] <= '0;
                end else if (mem_wr_en && (sel_addr == ADDR_W'(gi))) begin
                    mem_reg[gi] <= wr_entry;
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Round-robin winner: first set req bit scanning last+1, last+2, ...
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0]    win_idx;
    logic                win_found;
    logic [IDX_W-1:0]    cand_idx;

    always_comb begin
        win_idx   = last_reg;
        win_found = 1'b0;
        cand_idx  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand_idx = IDX_W'((int'(last_reg) + i) % NREQ);
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sequencer
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        ack_next   = '0;
        rdata_next = rdata_reg;
        last_next  = last_reg;
        mem_wr_en  = 1'b0;
`ifdef REGFILE_ARB_PARITY_EN
        perr_next  = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (win_found) begin
                    gnt_next   = NREQ'(1) << win_idx;
                    last_next  = win_idx;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (sel_req) begin
                    if (sel_we) begin
                        mem_wr_en  = 1'b1;
                        rdata_next = sel_wdata;
                    end else begin
                        rdata_next = rd_data;
`ifdef REGFILE_ARB_PARITY_EN
                        perr_next  = ^rd_entry;
`endif
                    end
                    ack_next   = gnt_reg;
                    state_next = ACK;
                end else begin
                    // Winner withdrew: abort without touching the array.
                    // last_reg stays advanced so the next scan moves on.
                    gnt_next   = '0;
                    state_next = IDLE;
                end
            end
            ACK: begin
                gnt_next   = '0;
                state_next = IDLE;
            end
            default: begin
                gnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            gnt_reg   <= '0;
            ack_reg   <= '0;
            rdata_reg <= '0;
            last_reg  <= IDX_W'(NREQ - 1);
`ifdef REGFILE_ARB_PARITY_EN
            perr_reg  <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            ack_reg   <= ack_next;
            rdata_reg <= rdata_next;
            last_reg  <= last_next;
`ifdef REGFILE_ARB_PARITY_EN
            perr_reg  <= perr_next;
`endif
        end
    end

    assign gnt   = gnt_reg;
    assign ack   = ack_reg;
    assign rdata = rdata_reg;
    assign busy  = (state_reg != IDLE);
`ifdef REGFILE_ARB_PARITY_EN
    assign perr  = perr_reg;
`endif

endmodule

// File: tb/tb_regfile_rr_arbiter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for regfile_rr_arbiter (NREQ=4, DATA_W=8, ADDR_W=5).
// Expected completions are pushed to a scoreboard queue when a request is
// driven; a negedge monitor pops and compares on every ack pulse.
// -----------------------------------------------------------------------------
module tb_regfile_rr_arbiter;

    localparam int NREQ   = 4;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;

    logic                   clk   = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NREQ-1:0]        req   = '0;
    logic [NREQ-1:0]        we    = '0;
    logic [NREQ*ADDR_W-1:0] addr  = '0;
    logic [NREQ*DATA_W-1:0] wdata = '0;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        ack;
    logic [DATA_W-1:0]      rdata;
    logic                   busy;
`ifdef REGFILE_ARB_PARITY_EN
    logic                   perr;
`endif

    regfile_rr_arbiter #(
        .NREQ   (NREQ),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .gnt   (gnt),
        .ack   (ack),
        .rdata (rdata),
`ifdef REGFILE_ARB_PARITY_EN
        .perr  (perr),
`endif
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0]   who;
        logic [DATA_W-1:0] data;
        logic              perr;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] model_mem [32];
    logic              exp_perr = 1'b0;
    int                n_compared = 0;
    int                n_mismatch = 0;
    int                cycle = 0;
    int                ack_cycles[$];

    always @(posedge clk) cycle++;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_compared++;
        if (obs !== expv) begin
            n_mismatch++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // Scoreboard monitor: every ack pulse consumes one expected completion.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && ack != '0) begin
            ack_cycles.push_back(cycle);
            $display("txn: cycle=%0d ack=%b rdata=%h", cycle, ack, rdata);
            if (exp_q.size() == 0) begin
                check_val("spurious_ack", 32'(ack), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("ack_who", 32'(ack), 32'(e.who));
                check_val("rdata", 32'(rdata), 32'(e.data));
`ifdef REGFILE_ARB_PARITY_EN
                check_val("perr", 32'(perr), 32'(e.perr));
`endif
            end
        end
    end

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model_mem[i] = '0;
    endtask

    task automatic set_port(input int k, input logic w, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
        logic [NREQ-1:0] bit_k;
        bit_k = NREQ'(1) << k;
        req = req | bit_k;
        we  = w ? (we | bit_k) : (we & ~bit_k);
        addr[k*ADDR_W +: ADDR_W]  = a;
        wdata[k*DATA_W +: DATA_W] = d;
    endtask

    task automatic push_exp(input int k, input logic w, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
        exp_t e;
        e.who = NREQ'(1) << k;
        if (w) begin
            model_mem[a] = d;
            e.data = d;
            e.perr = 1'b0;
        end else begin
            e.data = model_mem[a];
            e.perr = exp_perr;
        end
        exp_q.push_back(e);
    endtask

    // Single isolated transaction; called just after a negedge with DUT idle.
    task automatic do_txn(input int k, input logic w, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
        set_port(k, w, a, d);
        push_exp(k, w, a, d);
        @(negedge clk);
        check_val("gnt_after_edge1", 32'(gnt), 32'(NREQ'(1) << k));
        check_val("busy_in_grant", 32'(busy), 32'd1);
        @(negedge clk);
        check_val("ack_after_edge2", 32'(ack), 32'(NREQ'(1) << k));
        req = req & ~(NREQ'(1) << k);
        @(negedge clk);
        check_val("busy_low_cycle3", 32'(busy), 32'd0);
        check_val("gnt_cleared", 32'(gnt), 32'd0);
    endtask

    // Wait (bounded) for a number of ack pulses, optionally dropping each
    // acked requester's req. Returns just after the negedge of the last ack.
    task automatic run_until_acks(input int target, input bit drop);
        int got;
        got = 0;
        for (int c = 0; c < 200 && got < target; c++) begin
            @(negedge clk);
            if (ack != '0) begin
                got++;
                if (drop) req = req & ~ack;
            end
        end
        check_val("acks_seen", 32'(got), 32'(target));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        clear_model();

        // Reset state
        #1;
        check_val("rst_gnt", 32'(gnt), 32'd0);
        check_val("rst_ack", 32'(ack), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_rdata", 32'(rdata), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single write, read-after-write by another requester, untouched read
        do_txn(0, 1'b1, 5'd3, 8'hA5);
        do_txn(2, 1'b0, 5'd3, 8'h00);
        do_txn(2, 1'b0, 5'd9, 8'h00);

        // Clean reset so the pointer restarts at requester 0
        rst_n = 1'b0;
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;

        // All four requesters held: order 0,1,2,3,0,1,2,3, 3 cycles each
        ack_cycles.delete();
        for (int k = 0; k < NREQ; k++) set_port(k, 1'b1, ADDR_W'(16 + k), DATA_W'(8'h40 + k));
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < NREQ; k++) push_exp(k, 1'b1, ADDR_W'(16 + k), DATA_W'(8'h40 + k));
        run_until_acks(8, 1'b0);
        req = '0;
        #1;
        if (ack_cycles.size() >= 5) begin
            check_val("txn_cycles", 32'(ack_cycles[1] - ack_cycles[0]), 32'd3);
            check_val("round_cycles", 32'(ack_cycles[4] - ack_cycles[0]), 32'd12);
        end else begin
            check_val("round_ack_count", 32'(ack_cycles.size()), 32'd5);
        end
        @(negedge clk);   // ACK -> IDLE
        check_val("idle_after_round", 32'(busy), 32'd0);
        do_txn(3, 1'b0, 5'd18, 8'h00);

        // Abort: req1 dropped during GRANT, no write, pointer moves to 2
        do_txn(1, 1'b1, 5'd7, 8'h11);
        set_port(1, 1'b1, 5'd7, 8'hEE);
        @(negedge clk);
        check_val("abort_gnt", 32'(gnt), 32'b0010);
        req = req & ~4'b0010;
        @(negedge clk);
        check_val("abort_gnt_clr", 32'(gnt), 32'd0);
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_no_ack", 32'(ack), 32'd0);
        set_port(0, 1'b0, 5'd3, 8'h00);
        set_port(2, 1'b0, 5'd7, 8'h00);
        push_exp(2, 1'b0, 5'd7, 8'h00);   // requester 2 wins after aborted 1
        push_exp(0, 1'b0, 5'd3, 8'h00);
        run_until_acks(2, 1'b1);
        @(negedge clk);

        // Reset asserted during ACK: outputs clear without a clock edge
        set_port(0, 1'b1, 5'd4, 8'h3C);
        push_exp(0, 1'b1, 5'd4, 8'h3C);
        @(negedge clk);
        @(negedge clk);
        check_val("pre_rst_ack", 32'(ack), 32'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_gnt", 32'(gnt), 32'd0);
        check_val("async_ack", 32'(ack), 32'd0);
        check_val("async_busy", 32'(busy), 32'd0);
        check_val("async_rdata", 32'(rdata), 32'd0);
        req = '0;
        clear_model();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_txn(1, 1'b0, 5'd3, 8'h00);
        do_txn(3, 1'b0, 5'd4, 8'h00);

`ifdef REGFILE_ARB_PARITY_EN
        // Parity: corrupt one stored data bit, read flags perr with ack
        do_txn(0, 1'b1, 5'd1, 8'h0F);
        force dut.mem_reg[1] = 9'h00E;
        model_mem[1] = 8'h0E;
        exp_perr = 1'b1;
        do_txn(1, 1'b0, 5'd1, 8'h00);
        release dut.mem_reg[1];
        exp_perr = 1'b0;
        do_txn(0, 1'b1, 5'd1, 8'h0F);
        do_txn(1, 1'b0, 5'd1, 8'h00);
`endif

        repeat (2) @(negedge clk);
        check_val("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
